// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared state encoding, control bundle and defaults for pipeline_control
package pipe_ctrl_pkg;

  // Default number of consecutive mem_busy cycles before the timeout flag sets
  localparam int MEM_TIMEOUT_DEFAULT = 16;

  // FSM state encoding, visible on state_o
  typedef logic [2:0] state_t;
  localparam state_t ST_RUN          = 3'd0;
  localparam state_t ST_LOAD_STALL   = 3'd1;
  localparam state_t ST_BRANCH_FLUSH = 3'd2;
  localparam state_t ST_MEM_WAIT     = 3'd3;
  localparam state_t ST_HALTED       = 3'd4;

  // All stage enables and flushes as a single bundle
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic id_ex_write;
    logic ex_mem_write;
    logic mem_wb_write;
    logic if_id_flush;
    logic id_ex_flush;
  } ctrl_t;

  // Canonical control patterns
  localparam ctrl_t CTRL_RUN    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam ctrl_t CTRL_STALL  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  localparam ctrl_t CTRL_BRANCH = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  localparam ctrl_t CTRL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

endpackage

// File: rtl/pipeline_control_if.sv
// rtl/pipeline_control_if.sv - hazard request / stage control bundle; PIPE_PERF_EN adds perf counters
interface pipe_ctrl_if;

  // Hazard and event requests into the controller
  logic       stall_req;
  logic       branch_taken;
  logic       mem_busy;
  logic       halt;

  // Stage enables, flushes and status out of the controller
  logic       pc_write;
  logic       if_id_write;
  logic       id_ex_write;
  logic       ex_mem_write;
  logic       mem_wb_write;
  logic       if_id_flush;
  logic       id_ex_flush;
  logic [2:0] state_o;
  logic       mem_timeout;

`ifdef PIPE_PERF_EN
  logic [15:0] stall_count;
  logic [15:0] flush_count;

  // Pipeline side: raises hazards, consumes enables
  modport master (
    output stall_req, branch_taken, mem_busy, halt,
    input  pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
    input  if_id_flush, id_ex_flush, state_o, mem_timeout,
    input  stall_count, flush_count
  );

  // Controller side
  modport slave (
    input  stall_req, branch_taken, mem_busy, halt,
    output pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
    output if_id_flush, id_ex_flush, state_o, mem_timeout,
    output stall_count, flush_count
  );
`else
  // Pipeline side: raises hazards, consumes enables
  modport master (
    output stall_req, branch_taken, mem_busy, halt,
    input  pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
    input  if_id_flush, id_ex_flush, state_o, mem_timeout
  );

  // Controller side
  modport slave (
    input  stall_req, branch_taken, mem_busy, halt,
    output pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
    output if_id_flush, id_ex_flush, state_o, mem_timeout
  );
`endif

endinterface

// File: rtl/busy_watchdog.sv
// rtl/busy_watchdog.sv - saturating consecutive-busy counter with sticky timeout flag
module busy_watchdog
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic busy,
  output logic timeout
);

  localparam int              CW    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0]   LIMIT = CW'(MEM_TIMEOUT);

  logic [CW-1:0] count_q, count_d;
  logic          timeout_q, timeout_d;

  // Count while busy, hold at the limit, restart on any idle cycle; flag latches on reaching the limit
  always_comb begin
    count_d = '0;
    if (busy) begin
      count_d = (count_q == LIMIT) ? count_q : count_q + 1'b1;
    end
    timeout_d = timeout_q | (count_d == LIMIT);
  end

  // Counter and sticky flag registers; only reset clears the flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;

endmodule

// File: rtl/pipeline_control.sv
// rtl/pipeline_control.sv - pipeline hazard FSM driving stage enables/flushes; PIPE_PERF_EN adds perf counters
module pipeline_control
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input logic        clk,
  input logic        reset_n,
  pipe_ctrl_if.slave bus
);

  state_t state_q, state_d;
  ctrl_t  ctrl;

  // Same-cycle control response and next state; priority halt > mem_busy > branch > stall.
  // A stall_req seen in LOAD_STALL or BRANCH_FLUSH is the stale copy of one already handled.
  always_comb begin
    ctrl    = CTRL_RUN;
    state_d = ST_RUN;
    if (!reset_n) begin
      ctrl    = CTRL_FREEZE;
      state_d = ST_RUN;
    end else if (state_q == ST_HALTED || bus.halt) begin
      ctrl    = CTRL_FREEZE;
      state_d = ST_HALTED;
    end else if (bus.mem_busy) begin
      ctrl    = CTRL_FREEZE;
      state_d = ST_MEM_WAIT;
    end else if (bus.branch_taken) begin
      ctrl    = CTRL_BRANCH;
      state_d = ST_BRANCH_FLUSH;
    end else if (bus.stall_req &&
                 state_q != ST_LOAD_STALL &&
                 state_q != ST_BRANCH_FLUSH) begin
      ctrl    = CTRL_STALL;
      state_d = ST_LOAD_STALL;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign bus.pc_write     = ctrl.pc_write;
  assign bus.if_id_write  = ctrl.if_id_write;
  assign bus.id_ex_write  = ctrl.id_ex_write;
  assign bus.ex_mem_write = ctrl.ex_mem_write;
  assign bus.mem_wb_write = ctrl.mem_wb_write;
  assign bus.if_id_flush  = ctrl.if_id_flush;
  assign bus.id_ex_flush  = ctrl.id_ex_flush;
  assign bus.state_o      = state_q;

  busy_watchdog #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset_n (reset_n),
    .busy    (bus.mem_busy),
    .timeout (bus.mem_timeout)
  );

`ifdef PIPE_PERF_EN
  logic [15:0] stall_count_q, stall_count_d;
  logic [15:0] flush_count_q, flush_count_d;

  // Stalled cycles are those with the PC held outside HALTED; flushes count accepted branches
  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (!ctrl.pc_write && state_q != ST_HALTED && stall_count_q != 16'hFFFF) begin
      stall_count_d = stall_count_q + 16'd1;
    end
    if (ctrl.if_id_flush && flush_count_q != 16'hFFFF) begin
      flush_count_d = flush_count_q + 16'd1;
    end
  end

  // Saturating performance counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_count_q <= 16'd0;
      flush_count_q <= 16'd0;
    end else begin
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign bus.stall_count = stall_count_q;
  assign bus.flush_count = flush_count_q;
`endif

endmodule

// File: doc/pipeline_control.md
PIPELINE_CONTROL -- requirements
Module: pipeline_control

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16, max consecutive mem_busy cycles before timeout flag.
REQ-002 SHALL have ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- stall_req  in  1  load-use stall request from the forwarding unit.
- branch_taken  in  1  branch resolved taken in EX.
- mem_busy  in  1  data memory not ready this cycle.
- halt  in  1  halt instruction retiring in WB.
- pc_write  out  1  PC register enable.
- if_id_write  out  1  IF/ID enable.
- id_ex_write  out  1  ID/EX enable.
- ex_mem_write  out  1  EX/MEM enable.
- mem_wb_write  out  1  MEM/WB enable.
- if_id_flush  out  1  IF/ID loads NOP.
- id_ex_flush  out  1  ID/EX loads bubble (regWrite=0, memWrite=0).
- state_o  out  3  current FSM state.
- mem_timeout  out  1  sticky memory-timeout flag.

Function
REQ-003 SHALL implement registered FSM with states RUN, LOAD_STALL, BRANCH_FLUSH, MEM_WAIT, HALTED.
REQ-004 SHALL drive all enable/flush outputs combinationally from current state and current inputs, so the response takes effect on the same clock edge as the request.
REQ-005 SHALL resolve events by priority halt > mem_busy > branch_taken > stall_req.
REQ-006 No event in RUN: all five enables 1, both flushes 0, stay RUN.
REQ-007 stall_req only: pc_write=0, if_id_write=0, id_ex_flush=1, later stages enabled; next state LOAD_STALL.
REQ-008 LOAD_STALL SHALL ignore stall_req for one cycle (exactly one bubble per load-use), behave as RUN for other events, then return to RUN.
REQ-009 branch_taken: all enables 1, if_id_flush=1, id_ex_flush=1; stall_req same cycle ignored; next state BRANCH_FLUSH.
REQ-010 BRANCH_FLUSH SHALL last one cycle, behave as RUN, ignore stale stall_req; next RUN.
REQ-011 mem_busy: all five enables 0, both flushes 0 (full freeze); branch_taken/stall_req ignored; next state MEM_WAIT.
REQ-012 MEM_WAIT SHALL hold freeze while mem_busy=1; on mem_busy=0 apply RUN rules to remaining inputs same cycle, next state per those rules.
REQ-013 Watchdog counter SHALL count consecutive mem_busy cycles, saturate at MEM_TIMEOUT, clear when mem_busy=0; reaching MEM_TIMEOUT SHALL set mem_timeout, which stays 1 until reset.
REQ-014 halt in any state: all enables 0, flushes 0, enter HALTED; HALTED SHALL be left only by reset.
REQ-015 state_o encoding: RUN=0, LOAD_STALL=1, BRANCH_FLUSH=2, MEM_WAIT=3, HALTED=4.

Reset
REQ-016 While reset_n=0: state RUN, all enables 0, flushes 0, watchdog 0, mem_timeout 0, perf counters 0.
REQ-017 Reset deassertion mid-operation SHALL resume from RUN on the next rising edge with no residual stall or flush.

Configuration
REQ-018 With PIPE_PERF_EN defined: 16-bit saturating outputs stall_count (cycles with pc_write=0 and state not HALTED) and flush_count (branch flushes) SHALL exist, cleared only by reset.
REQ-019 Without PIPE_PERF_EN: those ports and counters SHALL be absent; all other behaviour identical.

Structure
REQ-020 Shared package pipe_ctrl_pkg SHALL hold the state enum/encoding and MEM_TIMEOUT default constant.
REQ-021 Watchdog SHALL be a sub-module busy_watchdog (inputs clk, reset_n, busy; output timeout).

Verification
REQ-022 stall_req=1 one cycle in RUN -> pc_write=0, if_id_write=0, id_ex_flush=1 that cycle; state_o=1 next cycle; stall_req held 2 cycles yields only one bubble.
REQ-023 branch_taken=1 and stall_req=1 same cycle -> if_id_flush=1, id_ex_flush=1, pc_write=1; state_o=2 then 0.
REQ-024 mem_busy=1 for 5 cycles with branch_taken=1 -> all enables 0 for 5 cycles, no flush; first cycle after mem_busy=0 flushes both stages.
REQ-025 mem_busy=1 for 16 cycles (MEM_TIMEOUT=16) -> mem_timeout=1, stays 1 after mem_busy=0 until reset_n=0.
REQ-026 halt=1 then reset_n pulse low -> HALTED (state_o=4, enables 0) until reset, then RUN with enables 1.
REQ-027 With PIPE_PERF_EN: three stalls and two branches -> stall_count=3, flush_count=2.
